// File: rtl/key_loader_pkg.sv
// key_loader_pkg: shared state encoding and default widths for the key loader.
package key_loader_pkg;
  localparam int KEY_W_DEF  = 128;
  localparam int BYTE_W_DEF = 8;
  localparam int NBYTES     = KEY_W_DEF / BYTE_W_DEF;
  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;
endpackage

// File: rtl/key_shadow_reg.sv
// key_shadow_reg: byte-addressable shadow register with clear; exposes its next value.
module key_shadow_reg
  import key_loader_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  localparam int NB    = KEY_W / BYTE_W,
  localparam int IW    = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [IW-1:0]     idx,
  input  logic [BYTE_W-1:0] data,
  output logic [KEY_W-1:0]  nxt
);
  logic [KEY_W-1:0] q;
  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign nxt[i*BYTE_W +: BYTE_W] = clr ? '0 :
                                     (we && idx == IW'(i)) ? data : q[i*BYTE_W +: BYTE_W];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= nxt;
endmodule

// File: rtl/key_loader.sv
// key_loader: byte-stream key assembly with atomic commit, lock and zeroize; KEY_LOADER_PARITY_EN adds in_par/par_err.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              key_lock,
  input  logic              key_clr,
`ifdef KEY_LOADER_PARITY_EN
  input  logic              in_par,
  output logic              par_err,
`endif
  output logic [KEY_W-1:0]  key,
  output logic              key_valid,
  output logic              key_upd
);
  localparam int NB = KEY_W / BYTE_W;
  localparam int IW = $clog2(NB);
  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt, widx;
  logic             acc, par_ok, we, commit;
  logic [KEY_W-1:0] shadow_nxt;
  assign in_ready = (state != PEND) && !key_clr;
  assign acc      = in_valid && in_ready;
`ifdef KEY_LOADER_PARITY_EN
  assign par_ok = ^{in_data, in_par};
`else
  assign par_ok = 1'b1;
`endif
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    widx      = idx;
    we        = 1'b0;
    commit    = 1'b0;
    if (key_clr) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else if (state == PEND) begin
      commit    = !key_lock;
      state_nxt = key_lock ? PEND : IDLE;
    end else if (acc && !par_ok) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else if (acc && in_sof) begin
      we        = 1'b1;
      widx      = '0;
      idx_nxt   = IW'(1);
      state_nxt = LOAD;
    end else if (acc && state == LOAD) begin
      we = 1'b1;
      // Last byte of the frame: commit now unless locked, then park in PEND.
      if (idx == IW'(NB - 1)) begin
        idx_nxt   = '0;
        commit    = !key_lock;
        state_nxt = key_lock ? PEND : IDLE;
      end else begin
        idx_nxt = idx + 1'b1;
      end
    end
  end
  key_shadow_reg #(.KEY_W(KEY_W), .BYTE_W(BYTE_W)) u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (key_clr),
    .we    (we),
    .idx   (widx),
    .data  (in_data),
    .nxt   (shadow_nxt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      key_upd   <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      key_upd   <= commit && !key_clr;
      key       <= key_clr ? '0 : commit ? shadow_nxt : key;
      key_valid <= !key_clr && (commit || key_valid);
    end
`ifdef KEY_LOADER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_err <= 1'b0;
    else par_err <= acc && !par_ok;
`endif
endmodule
